// File: rtl/defines_package.sv
// Shared types for the edge rasterizer: vertex/triangle/colour typedefs,
// default screen size and the sequencing state enum.
package defines_package;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef logic [7:0] Color;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Point3D;

  typedef struct packed {
    Point3D p;
    Point3D q;
    Point3D r;
  } Triangle3D;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    STEP,
    DONE
  } raster_state_t;

endpackage

// File: rtl/line_stepper.sv
// Bresenham walker for one edge. o_x/o_y give the position the walker will hold
// next cycle (after load/advance), so the caller can register an address from it.
module line_stepper
  import defines_package::*;
#(
  parameter int COORD_W = 11
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_load,
  input  logic                      i_advance,
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  output logic signed [COORD_W:0]   o_x,
  output logic signed [COORD_W:0]   o_y,
  output logic                      o_last
);

  localparam int CW1 = COORD_W + 1;
  localparam int EW  = COORD_W + 3;

  logic signed [CW1-1:0] r_x, r_y, r_x1, r_y1, r_dx, r_dy;
  logic                  r_sx, r_sy;
  logic signed [EW-1:0]  r_err;

  logic signed [CW1-1:0] w_x0e, w_y0e, w_x1e, w_y1e, w_ddx, w_ddy;
  logic signed [CW1-1:0] w_dx_ld, w_dy_ld, w_x_stp, w_y_stp;
  logic signed [CW1-1:0] w_one;
  logic signed [EW-1:0]  w_err_ld, w_err_stp, w_e2, w_dxe, w_dye, w_zero;
  logic                  w_mx, w_my;

  assign w_one  = CW1'(1);
  assign w_zero = EW'(0);

  assign w_x0e = CW1'(i_x0);
  assign w_y0e = CW1'(i_y0);
  assign w_x1e = CW1'(i_x1);
  assign w_y1e = CW1'(i_y1);
  assign w_ddx = w_x1e - w_x0e;
  assign w_ddy = w_y1e - w_y0e;

  // dx is kept positive and dy negative so a single error term covers all octants
  assign w_dx_ld  = w_ddx[CW1-1] ? -w_ddx : w_ddx;
  assign w_dy_ld  = w_ddy[CW1-1] ? w_ddy : -w_ddy;
  assign w_err_ld = EW'(w_dx_ld) + EW'(w_dy_ld);

  assign w_e2      = r_err <<< 1;
  assign w_dxe     = EW'(r_dx);
  assign w_dye     = EW'(r_dy);
  assign w_mx      = (w_e2 >= w_dye);
  assign w_my      = (w_e2 <= w_dxe);
  assign w_err_stp = r_err + (w_mx ? w_dye : w_zero) + (w_my ? w_dxe : w_zero);
  assign w_x_stp   = w_mx ? (r_sx ? r_x + w_one : r_x - w_one) : r_x;
  assign w_y_stp   = w_my ? (r_sy ? r_y + w_one : r_y - w_one) : r_y;

  assign o_x    = i_load ? w_x0e : (i_advance ? w_x_stp : r_x);
  assign o_y    = i_load ? w_y0e : (i_advance ? w_y_stp : r_y);
  assign o_last = (r_x == r_x1) && (r_y == r_y1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_x1  <= '0;
      r_y1  <= '0;
      r_dx  <= '0;
      r_dy  <= '0;
      r_sx  <= 1'b0;
      r_sy  <= 1'b0;
      r_err <= '0;
    end else begin
      r_x <= o_x;
      r_y <= o_y;
      if (i_load) begin
        r_x1  <= w_x1e;
        r_y1  <= w_y1e;
        r_dx  <= w_dx_ld;
        r_dy  <= w_dy_ld;
        r_sx  <= ~w_ddx[CW1-1];
        r_sy  <= ~w_ddy[CW1-1];
        r_err <= w_err_ld;
      end else if (i_advance) begin
        r_err <= w_err_stp;
      end
    end
  end

endmodule

// File: rtl/edge_rasterizer.sv
// Wireframe triangle rasterizer: walks p->q, q->r, r->p and emits one framebuffer
// write per covered pixel over valid/ready. RASTER_CLIP_EN suppresses off-screen pixels.
module edge_rasterizer
  import defines_package::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COORD_W = 11,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  Triangle3D         i_triangle,
  input  logic [PIX_W-1:0]  i_color,
  output logic              busy,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ADDR_W-1:0] px_addr,
  output logic [PIX_W-1:0]  px_data,
  output logic              done
);

  localparam int CW1     = COORD_W + 1;
  localparam int MUL_RAW = COORD_W + 2 + $clog2(WIDTH + 1);
  localparam int MUL_W   = (MUL_RAW > ADDR_W) ? MUL_RAW : ADDR_W;

  raster_state_t r_state, w_state_nxt;
  logic [1:0]    r_edge, w_edge_nxt;

  logic signed [COORD_W-1:0] r_px, r_py, r_qx, r_qy, r_rx, r_ry;
  logic signed [COORD_W-1:0] w_x0, w_y0, w_x1, w_y1;
  logic [PIX_W-1:0]          r_color;
  logic                      r_busy, r_valid, r_done;
  logic [ADDR_W-1:0]         r_addr;

  logic                  w_load, w_advance, w_fire, w_last, w_onscr;
  logic signed [CW1-1:0] w_x_nxt, w_y_nxt;
  logic signed [MUL_W-1:0] w_addr_full;
  logic                  w_unused;

  always_comb begin
    w_x0 = r_rx;
    w_y0 = r_ry;
    w_x1 = r_px;
    w_y1 = r_py;
    case (r_edge)
      2'd0: begin
        w_x0 = r_px; w_y0 = r_py; w_x1 = r_qx; w_y1 = r_qy;
      end
      2'd1: begin
        w_x0 = r_qx; w_y0 = r_qy; w_x1 = r_rx; w_y1 = r_ry;
      end
      default: ;
    endcase
  end

  line_stepper #(
    .COORD_W (COORD_W)
  ) u_stepper (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (w_x0),
    .i_y0      (w_y0),
    .i_x1      (w_x1),
    .i_y1      (w_y1),
    .o_x       (w_x_nxt),
    .o_y       (w_y_nxt),
    .o_last    (w_last)
  );

  // a suppressed (clipped) pixel retires on its own cycle without a handshake
  assign w_fire = (r_state == STEP) && (!r_valid || px_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_edge_nxt  = r_edge;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = LOAD;
      LOAD: begin
        w_edge_nxt  = 2'd0;
        w_state_nxt = SETUP;
      end
      SETUP: begin
        w_load      = 1'b1;
        w_state_nxt = STEP;
      end
      STEP: begin
        if (w_fire) begin
          if (!w_last) begin
            w_advance = 1'b1;
          end else if (r_edge == 2'd2) begin
            w_state_nxt = DONE;
          end else begin
            w_edge_nxt  = r_edge + 2'd1;
            w_state_nxt = SETUP;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef RASTER_CLIP_EN
  localparam logic signed [CW1-1:0] W_LIM = CW1'(WIDTH);
  localparam logic signed [CW1-1:0] H_LIM = CW1'(HEIGHT);
  assign w_onscr = !w_x_nxt[CW1-1] && (w_x_nxt < W_LIM) &&
                   !w_y_nxt[CW1-1] && (w_y_nxt < H_LIM);
`else
  assign w_onscr = 1'b1;
`endif

  assign w_addr_full = MUL_W'(w_y_nxt) * MUL_W'(WIDTH) + MUL_W'(w_x_nxt);
  assign w_unused    = ^{i_triangle, w_addr_full};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_edge  <= 2'd0;
      r_px    <= '0;
      r_py    <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_edge  <= w_edge_nxt;
      if (r_state == LOAD) begin
        r_px    <= i_triangle.p.x[COORD_W-1:0];
        r_py    <= i_triangle.p.y[COORD_W-1:0];
        r_qx    <= i_triangle.q.x[COORD_W-1:0];
        r_qy    <= i_triangle.q.y[COORD_W-1:0];
        r_rx    <= i_triangle.r.x[COORD_W-1:0];
        r_ry    <= i_triangle.r.y[COORD_W-1:0];
        r_color <= i_color;
      end
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      r_valid <= (w_state_nxt == STEP) && w_onscr;
      // position is unchanged while stalled, so the address holds too
      if (w_state_nxt == STEP) r_addr <= w_addr_full[ADDR_W-1:0];
    end
  end

  assign busy     = r_busy;
  assign px_valid = r_valid;
  assign px_addr  = r_addr;
  assign px_data  = r_color;
  assign done     = r_done;

endmodule
